// File: rtl/word_serializer_if.sv
// Word-in / beat-out stream bundle for word_serializer.
// last_out exists only when WORD_SERIALIZER_LAST_EN is defined.
interface word_serializer_if #(
  parameter int unsigned BEATS  = 4,
  parameter int unsigned BEAT_W = 8
);
  logic [BEATS*BEAT_W-1:0] data_in;
  logic                    valid_in;
  logic                    ready_out;
  logic [BEAT_W-1:0]       data_out;
  logic                    valid_out;
  logic                    ready_in;
`ifdef WORD_SERIALIZER_LAST_EN
  logic                    last_out;
`endif

  // Serializer side: consumes words, produces beats.
  modport slave (
    input  data_in,
    input  valid_in,
    input  ready_in,
`ifdef WORD_SERIALIZER_LAST_EN
    output last_out,
`endif
    output ready_out,
    output data_out,
    output valid_out
  );

  // Environment side: produces words, consumes beats.
  modport master (
    output data_in,
    output valid_in,
    output ready_in,
`ifdef WORD_SERIALIZER_LAST_EN
    input  last_out,
`endif
    input  ready_out,
    input  data_out,
    input  valid_out
  );
endinterface

// File: rtl/word_serializer.sv
// Splits one BEATS*BEAT_W word into BEATS narrow beats, beat 0 first, with a one-word
// pending buffer so back-to-back words stream without a bubble. Optional: WORD_SERIALIZER_LAST_EN.
module word_serializer #(
  parameter int unsigned BEATS  = 4,
  parameter int unsigned BEAT_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  word_serializer_if.slave  bus
);
  localparam int unsigned WordW = BEATS * BEAT_W;
  localparam int unsigned CntW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(BEATS - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e            state_q;
  logic [WordW-1:0]  active_q;
  logic [WordW-1:0]  pending_q;
  logic              pending_full_q;
  logic [CntW-1:0]   cnt_q;
  logic [BEAT_W-1:0] data_out_q;
  logic              valid_out_q;

  logic accept;
  logic xfer;
  logic final_xfer;

  always_comb begin
    accept     = bus.valid_in && !pending_full_q;
    xfer       = valid_out_q && bus.ready_in;
    final_xfer = xfer && (cnt_q == LastCnt);
  end

  // active_q holds the not-yet-presented beats; data_out_q is the beat on the wire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      cnt_q          <= '0;
      data_out_q     <= '0;
      valid_out_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            data_out_q  <= bus.data_in[BEAT_W-1:0];
            active_q    <= bus.data_in >> BEAT_W;
            cnt_q       <= '0;
            valid_out_q <= 1'b1;
            state_q     <= StSend;
          end
        end
        StSend: begin
          if (xfer) begin
            if (!final_xfer) begin
              data_out_q <= active_q[BEAT_W-1:0];
              active_q   <= active_q >> BEAT_W;
              cnt_q      <= cnt_q + 1'b1;
            end else if (pending_full_q) begin
              data_out_q     <= pending_q[BEAT_W-1:0];
              active_q       <= pending_q >> BEAT_W;
              pending_full_q <= 1'b0;
              cnt_q          <= '0;
            end else if (accept) begin
              data_out_q <= bus.data_in[BEAT_W-1:0];
              active_q   <= bus.data_in >> BEAT_W;
              cnt_q      <= '0;
            end else begin
              valid_out_q <= 1'b0;
              cnt_q       <= '0;
              state_q     <= StIdle;
            end
          end
          // A word arriving on the final beat with pending empty went straight to active.
          if (accept && !final_xfer) begin
            pending_q      <= bus.data_in;
            pending_full_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ready_out = !pending_full_q;
  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;
`ifdef WORD_SERIALIZER_LAST_EN
  assign bus.last_out  = valid_out_q && (cnt_q == LastCnt);
`endif
endmodule

// File: tb/tb_word_serializer.sv
// Table-driven bench for word_serializer (BEATS=4, BEAT_W=8) plus a hand-written mid-word reset.
module tb_word_serializer;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  word_serializer_if #(.BEATS(4), .BEAT_W(8)) bus ();

  word_serializer #(.BEATS(4), .BEAT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs applied for the coming edge, and outputs expected during that same cycle.
  typedef struct {
    logic        vin;
    logic [31:0] din;
    logic        rin;
    logic        ev;
    logic [7:0]  ed;
    logic        er;
    logic        el;
  } vec_t;

  vec_t vq[$];

  function automatic void add(logic vin, logic [31:0] din, logic rin,
                              logic ev, logic [7:0] ed, logic er, logic el);
    vec_t v;
    v.vin = vin; v.din = din; v.rin = rin;
    v.ev  = ev;  v.ed  = ed;  v.er  = er;  v.el = el;
    vq.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(string tag, logic ev, logic [7:0] ed, logic er, logic el);
    chk({tag, " valid_out"}, {31'd0, bus.valid_out}, {31'd0, ev});
    chk({tag, " data_out"}, {24'd0, bus.data_out}, {24'd0, ed});
    chk({tag, " ready_out"}, {31'd0, bus.ready_out}, {31'd0, er});
`ifdef WORD_SERIALIZER_LAST_EN
    chk({tag, " last_out"}, {31'd0, bus.last_out}, {31'd0, el});
`else
    if (el === 1'bx) $display("unexpected x in last column");
`endif
  endtask

  task automatic run_table(string tag);
    foreach (vq[i]) begin
      @(negedge clk);
      check_outs($sformatf("%s[%0d]", tag, i), vq[i].ev, vq[i].ed, vq[i].er, vq[i].el);
      bus.valid_in = vq[i].vin;
      bus.data_in  = vq[i].din;
      bus.ready_in = vq[i].rin;
    end
    vq.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n        = 1'b1;
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    bus.ready_in = 1'b0;
    #3 rst_n = 1'b0;
    #1 check_outs("reset", 1'b0, 8'h00, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single word, no backpressure.
    add(1, 32'h44332211, 1, 0, 8'h00, 1, 0);
    add(0, 32'h0,        1, 1, 8'h11, 1, 0);
    add(0, 32'h0,        1, 1, 8'h22, 1, 0);
    add(0, 32'h0,        1, 1, 8'h33, 1, 0);
    add(0, 32'h0,        1, 1, 8'h44, 1, 1);
    add(0, 32'h0,        1, 0, 8'h44, 1, 0);
    // Back-to-back words: second goes to pending, no bubble between 44 and 55.
    add(1, 32'h44332211, 1, 0, 8'h44, 1, 0);
    add(1, 32'h88776655, 1, 1, 8'h11, 1, 0);
    add(0, 32'h0,        1, 1, 8'h22, 0, 0);
    add(0, 32'h0,        1, 1, 8'h33, 0, 0);
    add(0, 32'h0,        1, 1, 8'h44, 0, 1);
    add(0, 32'h0,        1, 1, 8'h55, 1, 0);
    add(0, 32'h0,        1, 1, 8'h66, 1, 0);
    add(0, 32'h0,        1, 1, 8'h77, 1, 0);
    add(0, 32'h0,        1, 1, 8'h88, 1, 1);
    add(0, 32'h0,        1, 0, 8'h88, 1, 0);
    // Backpressure: BB held for three stalled cycles.
    add(1, 32'hDDCCBBAA, 1, 0, 8'h88, 1, 0);
    add(0, 32'h0,        1, 1, 8'hAA, 1, 0);
    add(0, 32'h0,        0, 1, 8'hBB, 1, 0);
    add(0, 32'h0,        0, 1, 8'hBB, 1, 0);
    add(0, 32'h0,        0, 1, 8'hBB, 1, 0);
    add(0, 32'h0,        1, 1, 8'hBB, 1, 0);
    add(0, 32'h0,        1, 1, 8'hCC, 1, 0);
    add(0, 32'h0,        1, 1, 8'hDD, 1, 1);
    add(0, 32'h0,        1, 0, 8'hDD, 1, 0);
    // Pending full: third word waits until the first word's final beat goes.
    add(1, 32'h04030201, 0, 0, 8'hDD, 1, 0);
    add(1, 32'h08070605, 0, 1, 8'h01, 1, 0);
    add(1, 32'h0C0B0A09, 0, 1, 8'h01, 0, 0);
    add(1, 32'h0C0B0A09, 1, 1, 8'h01, 0, 0);
    add(1, 32'h0C0B0A09, 1, 1, 8'h02, 0, 0);
    add(1, 32'h0C0B0A09, 1, 1, 8'h03, 0, 0);
    add(1, 32'h0C0B0A09, 1, 1, 8'h04, 0, 1);
    add(1, 32'h0C0B0A09, 1, 1, 8'h05, 1, 0);
    add(0, 32'h0,        1, 1, 8'h06, 0, 0);
    add(0, 32'h0,        1, 1, 8'h07, 0, 0);
    add(0, 32'h0,        1, 1, 8'h08, 0, 1);
    add(0, 32'h0,        1, 1, 8'h09, 1, 0);
    add(0, 32'h0,        1, 1, 8'h0A, 1, 0);
    add(0, 32'h0,        1, 1, 8'h0B, 1, 0);
    add(0, 32'h0,        1, 1, 8'h0C, 1, 1);
    add(0, 32'h0,        1, 0, 8'h0C, 1, 0);
    run_table("main");

    // Reset in the middle of a word, right after beat 22 is presented.
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.data_in  = 32'h44332211;
    bus.ready_in = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0;
    chk("midword beat0", {24'd0, bus.data_out}, 32'h11);
    @(negedge clk);
    chk("midword beat1", {24'd0, bus.data_out}, 32'h22);
    #2 rst_n = 1'b0;
    #1 check_outs("async_reset", 1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    add(1, 32'h0A0B0C0D, 1, 0, 8'h00, 1, 0);
    add(0, 32'h0,        1, 1, 8'h0D, 1, 0);
    add(0, 32'h0,        1, 1, 8'h0C, 1, 0);
    add(0, 32'h0,        1, 1, 8'h0B, 1, 0);
    add(0, 32'h0,        1, 1, 8'h0A, 1, 1);
    add(0, 32'h0,        1, 0, 8'h0A, 1, 0);
    // Back-to-back with stalls on both final beats; last stays up while stalled.
    add(1, 32'h44332211, 1, 0, 8'h0A, 1, 0);
    add(1, 32'h88776655, 1, 1, 8'h11, 1, 0);
    add(0, 32'h0,        1, 1, 8'h22, 0, 0);
    add(0, 32'h0,        1, 1, 8'h33, 0, 0);
    add(0, 32'h0,        0, 1, 8'h44, 0, 1);
    add(0, 32'h0,        0, 1, 8'h44, 0, 1);
    add(0, 32'h0,        1, 1, 8'h44, 0, 1);
    add(0, 32'h0,        1, 1, 8'h55, 1, 0);
    add(0, 32'h0,        1, 1, 8'h66, 1, 0);
    add(0, 32'h0,        1, 1, 8'h77, 1, 0);
    add(0, 32'h0,        0, 1, 8'h88, 1, 1);
    add(0, 32'h0,        1, 1, 8'h88, 1, 1);
    add(0, 32'h0,        1, 0, 8'h88, 1, 0);
    run_table("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
